// File: rtl/wb_arbiter.sv
// wb_arbiter -- two-requester register-file write-port arbiter.
//
// Requester 0 (ALU) and requester 1 (memory load) compete for a single
// register-file write port. Grants (ack0/ack1) are combinational; the
// granted address/data appear on the registered write port one cycle later
// together with a one-hot write-enable decode. Register 0 is never written:
// its grant is acked and produces wvalid, but we_onehot stays zero.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   hold                 register file busy, blocks all grants
//   req0/1, addr0/1,     write requests (held stable until acked)
//   data0/1
//   ack0, ack1           combinational one-cycle grant pulses
//   wvalid, waddr,       registered write port
//   wdata, we_onehot
//   conflicts            saturating count of unheld cycles with both requests
//
// Configuration macro:
//   WBARB_FIXED_PRIO_EN  defined   -> requester 0 always wins a conflict
//                        undefined -> round-robin on a last-grant pointer
module wb_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        req0,
  input  logic        req1,
  input  logic [4:0]  addr0,
  input  logic [4:0]  addr1,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  output logic        ack0,
  output logic        ack1,
  output logic        wvalid,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic [31:0] we_onehot,
  output logic [7:0]  conflicts
);

  typedef struct packed {
    logic        vld;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] we;
  } wr_t;

  wr_t        wr_q, wr_d;
  logic [7:0] conf_q, conf_d;
  logic       both, win0, gnt0, gnt1;

`ifndef WBARB_FIXED_PRIO_EN
  // Index of the most recently granted requester; reset to 1 so that
  // requester 0 wins the first conflict.
  logic last_q, last_d;
`endif

  // Register 0 is hard-wired, so its decode is all-zero.
  function automatic logic [31:0] dec(input logic [4:0] a);
    dec = (a == 5'd0) ? 32'd0 : (32'd1 << a);
  endfunction

  always_comb begin
    both = req0 & req1 & ~hold;
`ifdef WBARB_FIXED_PRIO_EN
    win0 = 1'b1;
`else
    win0 = last_q;  // requester 1 went last -> requester 0's turn
`endif
    // rst_n gating keeps acks low while in reset.
    gnt0 = rst_n & ~hold & req0 & (~req1 | win0);
    gnt1 = rst_n & ~hold & req1 & ~gnt0;

    // Address/data hold when idle; valid and enables clear.
    wr_d     = wr_q;
    wr_d.vld = 1'b0;
    wr_d.we  = '0;
    if (gnt0) begin
      wr_d.vld  = 1'b1;
      wr_d.addr = addr0;
      wr_d.data = data0;
      wr_d.we   = dec(addr0);
    end else if (gnt1) begin
      wr_d.vld  = 1'b1;
      wr_d.addr = addr1;
      wr_d.data = data1;
      wr_d.we   = dec(addr1);
    end

    conf_d = conf_q;
    if (both && conf_q != 8'hFF) conf_d = conf_q + 8'd1;

`ifndef WBARB_FIXED_PRIO_EN
    last_d = last_q;
    if (gnt0) last_d = 1'b0;
    if (gnt1) last_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q   <= '0;
      conf_q <= '0;
`ifndef WBARB_FIXED_PRIO_EN
      last_q <= 1'b1;
`endif
    end else begin
      wr_q   <= wr_d;
      conf_q <= conf_d;
`ifndef WBARB_FIXED_PRIO_EN
      last_q <= last_d;
`endif
    end
  end

  assign ack0      = gnt0;
  assign ack1      = gnt1;
  assign wvalid    = wr_q.vld;
  assign waddr     = wr_q.addr;
  assign wdata     = wr_q.data;
  assign we_onehot = wr_q.we;
  assign conflicts = conf_q;

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset; ports are clk and rst_n.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst_n  input  1  synchronous active-low reset.
REQ-004 SHALL have port: hold  input  1  register file busy; blocks new grants.
REQ-005 SHALL have ports: req0, req1  input  1 each  write request from requester 0 (ALU) and requester 1 (memory load).
REQ-006 SHALL have ports: addr0, addr1  input  5 each  destination register number.
REQ-007 SHALL have ports: data0, data1  input  32 each  write data.
REQ-008 SHALL have ports: ack0, ack1  output  1 each  grant, combinational, one-cycle pulse.
REQ-009 SHALL have port: wvalid  output  1  registered write-port valid.
REQ-010 SHALL have port: waddr  output  5  registered write address.
REQ-011 SHALL have port: wdata  output  32  registered write data.
REQ-012 SHALL have port: we_onehot  output  32  registered one-hot register write enables, bit n = register n.
REQ-013 SHALL have port: conflicts  output  8  saturating count of cycles where both requests were pending and not held.

Function
REQ-014 Requester i SHALL hold req_i, addr_i and data_i stable from assertion until the cycle ack_i is high; it may deassert or present a new request the following cycle.
REQ-015 ack_i SHALL be high only when req_i=1 and hold=0; at most one ack is high per cycle.
REQ-016 Exactly one requester SHALL be granted when hold=0 and at least one req is high; a lone request is granted that cycle.
REQ-017 Round-robin: when both requests are pending, the requester not granted most recently SHALL win; a 1-bit last-grant pointer updates only on a grant.
REQ-018 The edge after a grant SHALL load wvalid=1, waddr/wdata from the granted requester; with no grant, wvalid=0 and waddr/wdata hold their values.
REQ-019 we_onehot SHALL be the 5:32 one-hot decode of the granted address, registered with wvalid; all-zero when wvalid=0.
REQ-020 A grant with address 0 SHALL be acked and SHALL set wvalid=1 with we_onehot all-zero ($zero never written).
REQ-021 Grant-to-write latency SHALL be exactly one cycle; back-to-back grants SHALL sustain one write per cycle.
REQ-022 hold=1 SHALL suppress all acks, leave the pointer unchanged and clear wvalid and we_onehot on the next edge.
REQ-023 conflicts SHALL increment by 1 on each edge where req0=req1=1 and hold=0, saturating at 255.

Reset
REQ-024 On a rising edge with rst_n=0: wvalid=0, waddr=0, wdata=0, we_onehot=0, conflicts=0, pointer=1 (requester 0 wins first conflict).
REQ-025 A request pending during reset SHALL NOT be acked or written; acks SHALL be 0 whenever rst_n=0; arbitration resumes on the first edge with rst_n=1.

Configuration
REQ-026 Macro WBARB_FIXED_PRIO_EN defined: requester 0 SHALL always win conflicts, pointer unused; conflicts counter still counts.
REQ-027 Macro WBARB_FIXED_PRIO_EN undefined: round-robin per REQ-017.

Verification
REQ-028 Reset, then req0=1 addr0=5 data0=0xDEADBEEF, hold=0 -> ack0=1 that cycle; next cycle wvalid=1, waddr=5, wdata=0xDEADBEEF, we_onehot=0x00000020.
REQ-029 After reset, req0=req1=1 for 4 cycles (each re-requesting after ack), addr0=1, addr1=2 -> acks alternate 0,1,0,1; we_onehot sequence 0x2,0x4,0x2,0x4; conflicts=4.
REQ-030 req1=1 addr1=0 data1=0x1234 -> ack1=1; next cycle wvalid=1, we_onehot=0x00000000.
REQ-031 hold=1 for 3 cycles with req0=1 addr0=31 -> no ack, wvalid=0; hold falls -> ack0 same cycle, next cycle we_onehot=0x80000000.
REQ-032 Drive conflicting requests for 300 cycles -> conflicts saturates at 255; rst_n=0 for one edge mid-sequence -> all outputs 0, next conflict granted to requester 0.
REQ-033 With WBARB_FIXED_PRIO_EN defined, repeat REQ-029 -> ack0 every cycle, ack1 never, conflicts=4.
